waveform_sequencer: RTL

WAVEFORM_SEQUENCER -- requirements
Module: waveform_sequencer

---
 rtl/waveform_sequencer.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/waveform_sequencer.sv
// Frame/phase sequencer for the display update engine; drives the waveform LUT and scan engine.
// Optional per-phase frame repetition is enabled by defining WFSEQ_REPEAT_EN.
module waveform_sequencer #(
  parameter int unsigned GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       mode,
  input  logic [GAP_W-1:0] gap,
  input  logic             abort,
  input  logic [6:0]       phase_count,
  input  logic             frame_done,
`ifdef WFSEQ_REPEAT_EN
  input  logic [3:0]       repeat_count,
`endif
  output logic [6:0]       phase,
  output logic [1:0]       phase_type,
  output logic             frame_start,
  output logic             busy,
  output logic             done,
  output logic             aborted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_PREFETCH,
    S_FRAME,
    S_SCAN,
    S_GAP,
    S_DONE
  } state_t;

  localparam logic [GAP_W-1:0] GAP_ONE = GAP_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [6:0]       r_phase;
  logic [1:0]       r_phase_type;
  logic [6:0]       r_total;
  logic [GAP_W-1:0] r_gap;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             w_abort_req;
  logic             w_last;

`ifdef WFSEQ_REPEAT_EN
  logic [3:0]       r_rep;
  logic [3:0]       r_rep_cnt;
  assign w_last = (r_phase == r_total - 7'd1) && (r_rep_cnt == r_rep);
`else
  assign w_last = (r_phase == r_total - 7'd1);
`endif

  // abort only matters while an update is actually running
  assign w_abort_req = abort && (r_state != S_IDLE) && (r_state != S_DONE);

  always_comb begin
    w_next      = r_state;
    frame_start = 1'b0;
    done        = 1'b0;
    busy        = (r_state != S_IDLE);
    aborted     = w_abort_req;
    case (r_state)
      S_IDLE:     if (start) w_next = S_LOAD;
      S_LOAD:     w_next = (phase_count == 7'd0) ? S_DONE : S_PREFETCH;
      S_PREFETCH: w_next = S_FRAME;
      S_FRAME: begin
        frame_start = ~w_abort_req;
        w_next      = S_SCAN;
      end
      S_SCAN: begin
        if (frame_done) begin
          if (w_last)               w_next = S_DONE;
          else if (r_gap == '0)     w_next = S_PREFETCH;
          else                      w_next = S_GAP;
        end
      end
      S_GAP:      if (r_gap_cnt == GAP_ONE) w_next = S_PREFETCH;
      S_DONE: begin
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default:    w_next = S_IDLE;
    endcase
    if (w_abort_req) w_next = S_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_phase_type <= '0;
      r_total      <= '0;
      r_gap        <= '0;
      r_gap_cnt    <= '0;
`ifdef WFSEQ_REPEAT_EN
      r_rep        <= '0;
      r_rep_cnt    <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_phase_type <= mode[1] ? 2'b10 : mode;
            r_gap        <= gap;
            r_phase      <= '0;
`ifdef WFSEQ_REPEAT_EN
            r_rep        <= repeat_count;
            r_rep_cnt    <= '0;
`endif
          end
        end
        S_LOAD: r_total <= phase_count;
        S_SCAN: begin
          if (frame_done && !w_abort_req && !w_last) begin
            r_gap_cnt <= r_gap;
`ifdef WFSEQ_REPEAT_EN
            if (r_rep_cnt == r_rep) begin
              r_rep_cnt <= '0;
              r_phase   <= r_phase + 7'd1;
            end else begin
              r_rep_cnt <= r_rep_cnt + 4'd1;
            end
`else
            r_phase <= r_phase + 7'd1;
`endif
          end
        end
        S_GAP:   r_gap_cnt <= r_gap_cnt - GAP_ONE;
        default: ;
      endcase
    end
  end

  assign phase      = r_phase;
  assign phase_type = r_phase_type;

endmodule
